// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: column-multiplexed 4x4 hex keypad scanner with debounce,
// one-event-per-press valid/ack handshake and a 32-bit shifting entry register.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-emit a held key every
// REPEAT_SCANS completed scans.
// Snapshot bit 4*c+r is row r observed while column c is driven (1 = key down).

module hex_keypad_scanner #(
    parameter int unsigned SCAN_TICKS     = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_SCANS   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    input  logic        key_ack,
    output logic        key_overrun,
    output logic        key_held,
    input  logic        clear,
    output logic [31:0] entry_value
);

    localparam int unsigned TickW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam int unsigned CntW  = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TickW-1:0] TickLast = TickW'(SCAN_TICKS - 1);
    localparam logic [CntW-1:0]  CntMax   = CntW'(DEBOUNCE_SCANS);

    // Nibble i holds the hex legend of snapshot bit i (i = 4*col + row).
    localparam logic [63:0] KeyMap = 64'hDCBA_F963_0852_E741;

    if (SCAN_TICKS < 4) begin : g_bad_scan_ticks
        $error("SCAN_TICKS must be at least 4");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat_scans
        $error("REPEAT_SCANS must be at least 1");
    end

    function automatic logic [3:0] decode_key(input logic [15:0] state);
        logic [3:0] code;
        code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (state[i]) code = KeyMap[4*i +: 4];
        end
        return code;
    endfunction

    logic [3:0]       row_meta_q, row_sync_q;
    logic [TickW-1:0] tick_q, tick_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [15:0]      snap_q, snap_d, snap_full;
    logic [15:0]      prev_snap_q, prev_snap_d;
    logic [CntW-1:0]  stable_cnt_q, stable_cnt_d;
    logic [15:0]      deb_state_q, deb_state_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_overrun_q, key_overrun_d;
    logic [31:0]      entry_q, entry_d;
    logic             last_tick, scan_done;
    logic             press_evt, rep_evt, evt;
    logic [3:0]       evt_code;

    // Two-flop synchronizer for the asynchronous row returns; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= row;
            row_sync_q <= row_meta_q;
        end
    end

    // Dwell counter, column rotation and snapshot capture.
    always_comb begin
        last_tick = (tick_q == TickLast);
        scan_done = last_tick && (col_idx_q == 2'd3);
        snap_full = snap_q;
        snap_full[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        tick_d    = tick_q + TickW'(1);
        col_idx_d = col_idx_q;
        snap_d    = snap_q;
        if (last_tick) begin
            tick_d    = '0;
            col_idx_d = col_idx_q + 2'd1;
            snap_d    = snap_full;
        end
    end

    // Debounce: accept a snapshot once it repeats DEBOUNCE_SCANS more times.
    always_comb begin
        prev_snap_d  = prev_snap_q;
        stable_cnt_d = stable_cnt_q;
        deb_state_d  = deb_state_q;
        if (scan_done) begin
            if (snap_full == prev_snap_q) begin
                if (stable_cnt_q != CntMax) stable_cnt_d = stable_cnt_q + CntW'(1);
            end else begin
                prev_snap_d  = snap_full;
                stable_cnt_d = '0;
            end
            if (stable_cnt_d == CntMax) deb_state_d = snap_full;
        end
    end

    // A press only counts when leaving the all-released state.
    always_comb begin
        press_evt = scan_done && (deb_state_q == 16'h0) && $onehot(deb_state_d);
        evt_code  = decode_key(deb_state_d);
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RepW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_SCANS - 1);

    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;

    // Count completed scans of an unchanged single-key state; fire on wrap.
    always_comb begin
        rep_cnt_d = rep_cnt_q;
        rep_evt   = 1'b0;
        if (scan_done) begin
            if (deb_state_d != deb_state_q) begin
                rep_cnt_d = '0;
            end else if ($onehot(deb_state_q)) begin
                if (rep_cnt_q == RepLast) begin
                    rep_cnt_d = '0;
                    rep_evt   = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + RepW'(1);
                end
            end
        end
    end

    // Auto-repeat counter state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_cnt_q <= '0;
        else     rep_cnt_q <= rep_cnt_d;
    end
`else
    // No auto-repeat: only press events are emitted.
    always_comb begin
        rep_evt = 1'b0;
    end
`endif

    // Handshake, overrun flag and entry shift; clear beats a same-edge shift.
    always_comb begin
        evt           = press_evt || rep_evt;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_overrun_d = key_overrun_q;
        entry_d       = entry_q;
        if (evt) begin
            key_code_d  = evt_code;
            key_valid_d = 1'b1;
            if (key_valid_q && !key_ack) key_overrun_d = 1'b1;
            entry_d = {entry_q[27:0], evt_code};
        end else if (key_valid_q && key_ack) begin
            key_valid_d = 1'b0;
        end
        if (clear) begin
            entry_d       = 32'h0;
            key_overrun_d = 1'b0;
        end
    end

    // Scan, debounce and output state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q        <= '0;
            col_idx_q     <= 2'd0;
            snap_q        <= 16'h0;
            prev_snap_q   <= 16'h0;
            stable_cnt_q  <= '0;
            deb_state_q   <= 16'h0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_overrun_q <= 1'b0;
            entry_q       <= 32'h0;
        end else begin
            tick_q        <= tick_d;
            col_idx_q     <= col_idx_d;
            snap_q        <= snap_d;
            prev_snap_q   <= prev_snap_d;
            stable_cnt_q  <= stable_cnt_d;
            deb_state_q   <= deb_state_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_overrun_q <= key_overrun_d;
            entry_q       <= entry_d;
        end
    end

    // Output decode.
    always_comb begin
        col         = ~(4'b0001 << col_idx_q);
        key_code    = key_code_q;
        key_valid   = key_valid_q;
        key_overrun = key_overrun_q;
        key_held    = $onehot(deb_state_q);
        entry_value = entry_q;
    end

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Bench for hex_keypad_scanner: scan-level vector table, hand-written corner
// sequences and a randomized run against a scan-level reference model.
// Honours KEYPAD_AUTOREPEAT_EN when the design is built with it.

module tb_hex_keypad_scanner;

    localparam int unsigned ScanTicks = 4;
    localparam int unsigned DebScans  = 2;
    localparam int unsigned RepScans  = 3;
    localparam int unsigned ScanCyc   = 4 * ScanTicks;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_overrun;
    logic        key_held;
    logic        clear;
    logic [31:0] entry_value;

    logic [15:0] keys;  // bit 4*c+r pressed
    logic [3:0]  kmap [4][4];

    int n_cmp = 0;
    int n_bad = 0;
    int ev_cnt;
    logic [3:0] last_code;

    hex_keypad_scanner #(
        .SCAN_TICKS    (ScanTicks),
        .DEBOUNCE_SCANS(DebScans),
        .REPEAT_SCANS  (RepScans)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ack    (key_ack),
        .key_overrun(key_overrun),
        .key_held   (key_held),
        .clear      (clear),
        .entry_value(entry_value)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) row = row & ~keys[4*c +: 4];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] key_of(input logic [15:0] s);
        logic [3:0] k;
        k = 4'h0;
        for (int i = 0; i < 16; i++) if (s[i]) k = kmap[i % 4][i / 4];
        return k;
    endfunction

    // ---------------- reference model (one call per full scan) ----------------
    logic        m_valid, m_ovr;
    logic [3:0]  m_code;
    logic [31:0] m_entry;
    logic [15:0] m_deb, m_last;
    int          m_run, m_rep;

    task automatic m_reset();
        m_valid = 0; m_ovr = 0; m_code = 0; m_entry = 0;
        m_deb = 0; m_last = 0; m_run = 1; m_rep = 0;
    endtask

    // ack/clr are applied on the first edge of the scan, keys held all scan.
    task automatic m_scan(input logic [15:0] k, input logic a, input logic c);
        logic [15:0] old;
        logic        emit;
        if (a && m_valid) m_valid = 0;
        if (c) begin m_entry = 0; m_ovr = 0; end
        if (k == m_last) m_run++;
        else begin m_last = k; m_run = 1; end
        old = m_deb;
        if (m_run >= DebScans + 1) m_deb = k;
        emit = (old == 0) && ($countones(m_deb) == 1);
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_deb != old) m_rep = 0;
        else if ($countones(m_deb) == 1) begin
            m_rep++;
            if (m_rep == RepScans) begin emit = 1; m_rep = 0; end
        end
`endif
        if (emit) begin
            if (m_valid) m_ovr = 1;
            m_valid = 1;
            m_code  = key_of(m_deb);
            m_entry = {m_entry[27:0], m_code};
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        rst = 1; key_ack = 0; clear = 0; keys = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic drive_scan(input logic [15:0] k, input logic a, input logic c);
        keys = k; key_ack = a; clear = c;
        @(posedge clk); #1;
        key_ack = 0; clear = 0;
        repeat (ScanCyc - 1) @(posedge clk);
        #1;
    endtask

    // One scan with ack/clear asserted only on its completion edge.
    task automatic scan_edge(input logic [15:0] k, input logic a, input logic c);
        keys = k;
        repeat (ScanCyc - 1) @(posedge clk);
        #1;
        key_ack = a; clear = c;
        @(posedge clk); #1;
        key_ack = 0; clear = 0;
    endtask

    // Hold keys for n scans with key_ack left as-is, counting valid cycles.
    task automatic hold_count(input logic [15:0] k, input int n);
        keys = k;
        for (int i = 0; i < n * ScanCyc; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin ev_cnt++; last_code = key_code; end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".col"},   32'(col), 32'hE);
        check({tag, ".code"},  32'(key_code), 32'h0);
        check({tag, ".valid"}, 32'(key_valid), 32'h0);
        check({tag, ".ovr"},   32'(key_overrun), 32'h0);
        check({tag, ".held"},  32'(key_held), 32'h0);
        check({tag, ".entry"}, entry_value, 32'h0);
    endtask

    typedef struct {
        logic [15:0] keys;
        logic        ack;
        logic        clr;
        logic        valid;
        logic [3:0]  code;
        logic        held;
        logic        ovr;
        logic [31:0] entry;
    } vec_t;

    localparam logic [15:0] K6 = 16'h0200, K4 = 16'h0002, K5 = 16'h0020, K9 = 16'h0400;
    localparam logic [15:0] K0 = 16'h0080, KD = 16'h8000, KA = 16'h1000;
    localparam logic [15:0] K1 = 16'h0001, K2 = 16'h0010, K3 = 16'h0100;

    vec_t        tbl [26];
    logic [15:0] digs [9];

    initial begin
        kmap = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                 '{4'h4, 4'h5, 4'h6, 4'hB},
                 '{4'h7, 4'h8, 4'h9, 4'hC},
                 '{4'hE, 4'h0, 4'hF, 4'hD}};
        digs = '{K1, K2, K3, K4, K5, K6, 16'h0004, 16'h0040, K9};

        //               keys      ack   clr   valid code  held  ovr   entry
        tbl[0]  = '{16'h0,    1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{K6,       1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{K6,       1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{K6,       1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 32'h6};
        tbl[4]  = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 32'h6};
        tbl[5]  = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h6, 1'b1, 1'b0, 32'h6};
        tbl[6]  = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h6, 1'b0, 1'b0, 32'h6};
        tbl[7]  = '{16'h0,    1'b1, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 32'h6};
        tbl[8]  = '{K4,       1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 32'h6};
        tbl[9]  = '{K4,       1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 1'b0, 32'h6};
        tbl[10] = '{K4,       1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[11] = '{K4 | K5,  1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[12] = '{K4 | K5,  1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[13] = '{K4 | K5,  1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 32'h64};
        tbl[14] = '{K4,       1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 32'h64};
        tbl[15] = '{K4,       1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 32'h64};
        tbl[16] = '{K4,       1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[17] = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[18] = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h4, 1'b1, 1'b0, 32'h64};
        tbl[19] = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 32'h64};
        tbl[20] = '{K9,       1'b0, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 32'h0};
        tbl[21] = '{K9,       1'b0, 1'b0, 1'b1, 4'h4, 1'b0, 1'b0, 32'h0};
        tbl[22] = '{K9,       1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b1, 32'h9};
        tbl[23] = '{16'h0,    1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 32'h0};
        tbl[24] = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 32'h0};
        tbl[25] = '{16'h0,    1'b0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 32'h0};

        // ---- reset values and idle column rotation ----
        rst = 1; key_ack = 0; clear = 0; keys = 0;
        #1;
        check_reset_vals("rst_async");
        do_reset();
        check_reset_vals("rst");
        for (int i = 0; i < 2 * ScanCyc; i++) begin
            check($sformatf("col[%0d]", i), 32'(col), 32'(~(4'b0001 << ((i / ScanTicks) % 4)) & 4'hF));
            @(posedge clk); #1;
        end
        check("idle.valid", 32'(key_valid), 32'h0);
        check("idle.entry", entry_value, 32'h0);

        // ---- scan-level vector table ----
        do_reset();
        for (int i = 0; i < 26; i++) begin
            drive_scan(tbl[i].keys, tbl[i].ack, tbl[i].clr);
            check($sformatf("tbl[%0d].valid", i), 32'(key_valid), 32'(tbl[i].valid));
            check($sformatf("tbl[%0d].code", i),  32'(key_code), 32'(tbl[i].code));
            check($sformatf("tbl[%0d].held", i),  32'(key_held), 32'(tbl[i].held));
            check($sformatf("tbl[%0d].ovr", i),   32'(key_overrun), 32'(tbl[i].ovr));
            check($sformatf("tbl[%0d].entry", i), entry_value, tbl[i].entry);
            check($sformatf("tbl[%0d].col", i),   32'(col), 32'hE);
        end

        // ---- bouncing press of '6', ack held high ----
        do_reset();
        key_ack = 1; ev_cnt = 0; last_code = 4'hF;
        for (int i = 0; i < 2 * ScanCyc; i++) begin
            if (i % 3 == 0) keys = keys ^ K6;
            @(posedge clk); #1;
            if (key_valid) begin ev_cnt++; last_code = key_code; end
        end
        hold_count(K6, 5);
        check("bounce.held", 32'(key_held), 32'h1);
        hold_count(16'h0, 4);
        check("bounce.events", 32'(ev_cnt), 32'h1);
        check("bounce.code", 32'(last_code), 32'h6);
        check("bounce.entry", entry_value, 32'h6);
        check("bounce.valid_acked", 32'(key_valid), 32'h0);
        key_ack = 0;

        // ---- 1..9 without ack: overrun, then clear ----
        do_reset();
        for (int d = 0; d < 9; d++) begin
            for (int s = 0; s < 3; s++) scan_edge(digs[d], 1'b0, 1'b0);
            for (int s = 0; s < 3; s++) scan_edge(16'h0, 1'b0, 1'b0);
        end
        check("seq9.ovr", 32'(key_overrun), 32'h1);
        check("seq9.code", 32'(key_code), 32'h9);
        check("seq9.valid", 32'(key_valid), 32'h1);
        check("seq9.entry", entry_value, 32'h23456789);
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        check("clr.entry", entry_value, 32'h0);
        check("clr.ovr", 32'(key_overrun), 32'h0);
        check("clr.valid", 32'(key_valid), 32'h1);
        check("clr.code", 32'(key_code), 32'h9);

        // ---- ack on the event edge; clear on the event edge ----
        do_reset();
        for (int s = 0; s < 3; s++) scan_edge(K1, 1'b0, 1'b0);
        for (int s = 0; s < 3; s++) scan_edge(16'h0, 1'b0, 1'b0);
        scan_edge(K2, 1'b0, 1'b0);
        scan_edge(K2, 1'b0, 1'b0);
        scan_edge(K2, 1'b1, 1'b0);
        check("ackevt.valid", 32'(key_valid), 32'h1);
        check("ackevt.code", 32'(key_code), 32'h2);
        check("ackevt.ovr", 32'(key_overrun), 32'h0);
        check("ackevt.entry", entry_value, 32'h12);
        key_ack = 1;
        @(posedge clk); #1;
        key_ack = 0;
        check("ack.valid", 32'(key_valid), 32'h0);
        for (int s = 0; s < 3; s++) scan_edge(16'h0, 1'b0, 1'b0);
        scan_edge(K3, 1'b0, 1'b0);
        scan_edge(K3, 1'b0, 1'b0);
        scan_edge(K3, 1'b0, 1'b1);
        check("clrevt.entry", entry_value, 32'h0);
        check("clrevt.code", 32'(key_code), 32'h3);
        check("clrevt.valid", 32'(key_valid), 32'h1);

        // ---- hold '0', add 'D', release 'D'; then reset mid-scan ----
        do_reset();
        key_ack = 1; ev_cnt = 0; last_code = 4'hF;
        hold_count(K0, 4);
        check("two.held_single", 32'(key_held), 32'h1);
        hold_count(K0 | KD, 4);
        check("two.held_multi", 32'(key_held), 32'h0);
        hold_count(K0, 4);
        check("two.held_back", 32'(key_held), 32'h1);
        hold_count(16'h0, 4);
        check("two.events", 32'(ev_cnt), 32'h1);
        check("two.code", 32'(last_code), 32'h0);
        key_ack = 0;
        for (int s = 0; s < 3; s++) scan_edge(K5, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #1;
        rst = 0; keys = 0;

        // ---- long hold of 'A' (auto-repeat if built in) ----
        do_reset();
        key_ack = 1; ev_cnt = 0; last_code = 4'hF;
        hold_count(KA, 12);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hold.events", 32'(ev_cnt), 32'd4);
`else
        check("hold.events", 32'(ev_cnt), 32'd1);
`endif
        check("hold.code", 32'(last_code), 32'hA);
        hold_count(16'h0, 4);
        key_ack = 0;

        // ---- randomized scans against the reference model ----
        do_reset();
        m_reset();
        begin
            int          left;
            logic [15:0] k;
            logic        a, c;
            left = 0; k = 0;
            for (int s = 0; s < 80; s++) begin
                if (left == 0) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2: k = 16'h0;
                        8, 9:    k = (16'h1 << $urandom_range(0, 15)) |
                                     (16'h1 << $urandom_range(0, 15));
                        default: k = 16'h1 << $urandom_range(0, 15);
                    endcase
                    left = $urandom_range(1, 6);
                end
                left--;
                a = ($urandom_range(0, 9) < 3);
                c = ($urandom_range(0, 19) == 0);
                drive_scan(k, a, c);
                m_scan(k, a, c);
                check($sformatf("rnd[%0d].valid", s), 32'(key_valid), 32'(m_valid));
                check($sformatf("rnd[%0d].code", s),  32'(key_code), 32'(m_code));
                check($sformatf("rnd[%0d].ovr", s),   32'(key_overrun), 32'(m_ovr));
                check($sformatf("rnd[%0d].held", s),  32'(key_held),
                      32'($countones(m_deb) == 1));
                check($sformatf("rnd[%0d].entry", s), entry_value, m_entry);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
